// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret sequencer (ports: ecall, mret, irqs, CSR views in; stall/flush/CSR write/redirect/busy out)
module trap_ctrl #(
  parameter int DRAIN_MAX = 15,
  parameter int UART_CODE = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall,
  input  logic        mret,
  input  logic        uart_irq,
  input  logic        timer_irq,
  input  logic [31:0] pres_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic        drained,
  output logic        stall,
  output logic        flush,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [31:0] UC = 32'(UART_CODE);
  typedef enum logic [2:0] {IDLE, DRAIN, W_EPC, W_CAUSE, W_STAT, REDIR, R_STAT} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] cause_l, pc_l, cause_sel, tgt, mst_trap, mst_ret;
  logic tmr_q, uart_q, ev, unused_mie;
  assign unused_mie = ^mie;
  assign tmr_q = timer_irq & mstatus[3] & mie[7];
  assign uart_q = uart_irq & mstatus[3] & mie[UART_CODE];
  assign ev = ecall | tmr_q | uart_q;
  assign cause_sel = ecall ? 32'h0000_000B : tmr_q ? 32'h8000_0007 : {1'b1, UC[30:0]};
  // vectored mode offsets by 4*code only for interrupts; shift drops bit 31/30 (mod 2^32)
  assign tgt = {mtvec[31:2], 2'b00} + ((mtvec[1:0] == 2'b01 && cause_l[31]) ? {cause_l[29:0], 2'b00} : 32'd0);
  assign mst_trap = {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
  assign mst_ret = {mstatus[31:13], 2'b11, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};
  always_comb begin
    nxt = IDLE;
    case (st)
      IDLE:    nxt = ev ? DRAIN : mret ? R_STAT : IDLE;
      DRAIN:   nxt = (drained || cnt == CW'(DRAIN_MAX - 1)) ? W_EPC : DRAIN;
      W_EPC:   nxt = W_CAUSE;
      W_CAUSE: nxt = W_STAT;
      W_STAT:  nxt = REDIR;
      R_STAT:  nxt = REDIR;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      cause_l <= '0;
      pc_l <= '0;
      stall <= 1'b0;
      flush <= 1'b0;
      csr_we <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      redirect <= 1'b0;
      redirect_pc <= '0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= (st == DRAIN) ? cnt + 1'b1 : '0;
      if (st == IDLE && ev) begin
        cause_l <= cause_sel;
        pc_l <= pres_pc;
      end
      stall <= nxt != IDLE && nxt != REDIR;
      busy <= nxt != IDLE;
      flush <= nxt == REDIR;
      redirect <= nxt == REDIR;
      redirect_pc <= (nxt == REDIR) ? ((st == R_STAT) ? mepc : tgt) : '0;
      csr_we <= nxt inside {W_EPC, W_CAUSE, W_STAT, R_STAT};
      csr_waddr <= (nxt == W_EPC) ? 12'h341 : (nxt == W_CAUSE) ? 12'h342 :
                   (nxt == W_STAT || nxt == R_STAT) ? 12'h300 : 12'h000;
      csr_wdata <= (nxt == W_EPC) ? {pc_l[31:2], 2'b00} : (nxt == W_CAUSE) ? cause_l :
                   (nxt == W_STAT) ? mst_trap : (nxt == R_STAT) ? mst_ret : 32'd0;
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector self-checking bench for trap_ctrl
module tb_trap_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic ecall = 0, mret = 0, uart_irq = 0, timer_irq = 0, drained = 1;
  logic [31:0] pres_pc = 0, mtvec = 0, mepc = 0, mstatus = 0, mie = 0;
  logic stall, flush, csr_we, redirect, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  int n_vec = 0, n_err = 0;
  trap_ctrl dut (
    .clk(clk), .rst(rst), .ecall(ecall), .mret(mret), .uart_irq(uart_irq), .timer_irq(timer_irq),
    .pres_pc(pres_pc), .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus), .mie(mie), .drained(drained),
    .stall(stall), .flush(flush), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // starts in the first DRAIN cycle, ends in the IDLE cycle after REDIR
  task automatic trap_seq(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] stat,
                          input logic [31:0] tgt, input int d, input bit poke);
    for (int i = 0; i < d; i++) begin
      check("drain", {busy, stall, csr_we, redirect}, 4'b1100);
      if (poke && i == 0) mret = 1;
      tick();
      mret = 0;
    end
    check("epc_we", {csr_we, stall, csr_waddr}, {2'b11, 12'h341});
    check("epc_d", csr_wdata, epc);
    tick();
    check("cause_a", {csr_we, csr_waddr}, {1'b1, 12'h342});
    check("cause_d", csr_wdata, cause);
    tick();
    check("stat_a", {csr_we, csr_waddr}, {1'b1, 12'h300});
    check("stat_d", csr_wdata, stat);
    tick();
    check("redir", {redirect, flush, stall, csr_we, busy}, 5'b11001);
    check("tgt", redirect_pc, tgt);
    tick();
    check("idle", {busy, stall, redirect, flush, csr_we}, 5'b0);
  endtask
  initial begin
    #1;
    check("rst_ctl", {stall, flush, csr_we, redirect, busy, csr_waddr}, 0);
    check("rst_dat", {csr_wdata, redirect_pc}, 0);
    #8 rst = 0;
    tick();
    check("idle0", busy, 0);
    // ecall with mret in the same cycle: ecall wins; mret pulse while busy is lost
    mstatus = 32'h8; mtvec = 32'h2000; pres_pc = 32'h100;
    ecall = 1; mret = 1;
    tick();
    ecall = 0; mret = 0;
    trap_seq(32'h100, 32'hB, 32'h1880, 32'h2000, 1, 1);
    // misaligned PC has its low bits dropped in mepc
    pres_pc = 32'h203; ecall = 1;
    tick();
    ecall = 0;
    trap_seq(32'h200, 32'hB, 32'h1880, 32'h2000, 1, 0);
    // vectored timer interrupt, deasserted after being latched
    mie = 32'h80; mtvec = 32'h2001; timer_irq = 1;
    tick();
    timer_irq = 0;
    trap_seq(32'h200, 32'h8000_0007, 32'h1880, 32'h201C, 1, 0);
    // all three at once: ecall first, then timer, then uart re-taken while still asserted
    mie = 32'h8000_0080; pres_pc = 32'h400; ecall = 1; timer_irq = 1; uart_irq = 1;
    tick();
    ecall = 0;
    trap_seq(32'h400, 32'hB, 32'h1880, 32'h2000, 1, 0);
    tick();
    timer_irq = 0;
    trap_seq(32'h400, 32'h8000_0007, 32'h1880, 32'h201C, 1, 0);
    tick();
    trap_seq(32'h400, 32'h8000_001F, 32'h1880, 32'h207C, 1, 0);
    // interrupts globally disabled: nothing taken
    mstatus = 32'h0;
    tick();
    check("irq_off", busy, 0);
    uart_irq = 0;
    // drain timeout: 15 DRAIN cycles, redirect at cycle 19
    mstatus = 32'h8; mtvec = 32'h3000; drained = 0; ecall = 1;
    tick();
    ecall = 0;
    trap_seq(32'h400, 32'hB, 32'h1880, 32'h3000, 15, 0);
    drained = 1;
    // mret
    mstatus = 32'h80; mepc = 32'h104; mret = 1;
    tick();
    mret = 0;
    check("rs_a", {csr_we, stall, busy, csr_waddr}, {3'b111, 12'h300});
    check("rs_d", csr_wdata, 32'h1888);
    tick();
    check("mret_redir", {redirect, flush, stall, csr_we}, 4'b1100);
    check("mret_tgt", redirect_pc, 32'h104);
    tick();
    check("mret_idle", busy, 0);
    // reset in W_CAUSE
    ecall = 1;
    tick();
    ecall = 0;
    tick();
    tick();
    check("pre_rst", {csr_we, csr_waddr}, {1'b1, 12'h342});
    rst = 1;
    #1;
    check("mid_rst_ctl", {stall, flush, csr_we, redirect, busy, csr_waddr}, 0);
    check("mid_rst_dat", {csr_wdata, redirect_pc}, 0);
    #2 rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst", {csr_we, busy, redirect}, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter DRAIN_MAX, default 15: maximum cycles spent in DRAIN before proceeding regardless of drained.
REQ-002 Parameter UART_CODE, default 31: interrupt cause code used for the UART IRQ.
REQ-003 The reset is rst, asynchronous, active-high, and the clock is clk; all state is clocked on the rising edge of clk.
REQ-004 Ports:
- clk, in, 1: clock.
- rst, in, 1: async reset, active-high.
- ecall, in, 1: single-cycle pulse, ecall in ID/EX.
- mret, in, 1: single-cycle pulse, mret in ID/EX.
- uart_irq, in, 1: level interrupt request.
- timer_irq, in, 1: level interrupt request.
- pres_pc, in, 32: PC of the instruction in ID/EX.
- mtvec, in, 32: current mtvec.
- mepc, in, 32: current mepc.
- mstatus, in, 32: current mstatus.
- mie, in, 32: current mie.
- drained, in, 1: pipeline has no in-flight writes.
- stall, out, 1: freeze IF/ID.
- flush, out, 1: kill IF/ID/EX contents.
- csr_we, out, 1: CSR write strobe.
- csr_waddr, out, 12: CSR write address.
- csr_wdata, out, 32: CSR write data.
- redirect, out, 1: load new PC.
- redirect_pc, out, 32: target PC.
- busy, out, 1: FSM not in IDLE.

Function
REQ-005 FSM states SHALL be IDLE, DRAIN, W_EPC, W_CAUSE, W_STAT, REDIR for trap entry, and R_STAT, REDIR for mret.
REQ-006 In IDLE, a trap event SHALL be selected by priority ecall > timer > UART; interrupts qualify only if mstatus[3]=1 and the enable bit (mie[7] timer, mie[UART_CODE] UART) is set.
REQ-007 On a selected event, the cause (ecall 0x0000000B; timer 0x80000007; UART {1'b1, UART_CODE[30:0]}) and pres_pc SHALL be latched, and the next state SHALL be DRAIN.
REQ-008 mret in IDLE with no qualifying event SHALL go to R_STAT; an ecall or qualifying interrupt in the same cycle SHALL win, and mret SHALL be dropped.
REQ-009 DRAIN SHALL assert stall and count cycles, exiting to W_EPC when drained=1 or the count reaches DRAIN_MAX.
REQ-010 W_EPC SHALL write 0x341 with the latched PC, with bits[1:0] forced to 0.
REQ-011 W_CAUSE SHALL write 0x342 with the latched cause.
REQ-012 W_STAT SHALL write 0x300 with mstatus, modified as: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
REQ-013 R_STAT SHALL write 0x300 with mstatus, modified as: MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
REQ-014 REDIR SHALL assert redirect and flush for exactly one cycle, then return to IDLE.
REQ-015 The trap target SHALL be {mtvec[31:2],2'b00}; if mtvec[1:0]=01 and the cause is an interrupt, the target SHALL be {mtvec[31:2],2'b00} + 4*code, mod 2^32.
REQ-016 The mret target SHALL be mepc sampled in R_STAT.
REQ-017 The mtvec value SHALL be sampled in W_STAT.
REQ-018 csr_we SHALL be high only in W_EPC, W_CAUSE, W_STAT, and R_STAT, one write per cycle.
REQ-019 csr_waddr and csr_wdata SHALL be 0 whenever csr_we=0.
REQ-020 stall SHALL be 1 in every non-IDLE state except REDIR.
REQ-021 busy SHALL be 1 in every non-IDLE state.
REQ-022 Events arriving while busy=1 SHALL be ignored; level IRQs are re-evaluated in IDLE, and an ecall/mret pulse arriving while busy is lost.
REQ-023 An interrupt deasserting after it has been latched SHALL NOT abort the sequence.
REQ-024 Latency SHALL be 4 + d cycles from ecall to redirect, where d is the number of DRAIN cycles (1..DRAIN_MAX); mret to redirect SHALL be 2 cycles.

Reset
REQ-025 On rst, the FSM SHALL go to IDLE and the DRAIN counter and latched cause/PC SHALL clear to 0.
REQ-026 On rst, all outputs SHALL be 0: stall, flush, csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, and busy.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence immediately, with no further CSR writes after reset.

Verification
REQ-028 ecall, pres_pc=0x100, mtvec=0x2000, drained=1 -> writes 0x341=0x100, 0x342=0xB, and 0x300 with MIE cleared; redirect_pc=0x2000 at cycle 5.
REQ-029 timer_irq with mstatus[3]=1, mie[7]=1, mtvec=0x2001 -> mcause=0x80000007, redirect_pc=0x201C.
REQ-030 uart_irq and timer_irq and ecall in the same cycle -> mcause=0xB; IRQs are re-taken after return only if still asserted and enabled.
REQ-031 drained held 0 -> exit from DRAIN after exactly 15 cycles; redirect at cycle 19.
REQ-032 mret with mstatus=0x80, mepc=0x104 -> 0x300 written with bit3=1 and bit7=1; redirect_pc=0x104.
REQ-033 rst asserted in W_CAUSE -> all outputs 0 in the same cycle; no 0x300 write; IDLE afterward.
